// File: rtl/nexus_nonce_dispatch_pkg.sv
// Shared constants and types for the SK1024 nonce dispatcher: datapath widths,
// hash-core stage counts (which set the default pipeline latency) and FSM states.
package nexus_nonce_dispatch_pkg;

    localparam int NONCE_W = 64;
    localparam int QWORD_W = 64;
    localparam int HASH_COUNT_W = 48;

    // One Skein block = round stages + key-injection stages; the core runs two
    // Skein blocks, three Keccak blocks and two glue registers back to back.
    localparam int SKEIN_ROUND_STAGES = 140;
    localparam int SKEIN_KEY_STAGES   = 18;
    localparam int KECCAK_STAGES      = 24;
    localparam int SKEIN_BLOCK_STAGES = SKEIN_ROUND_STAGES + SKEIN_KEY_STAGES;
    localparam int PIPE_LATENCY_DEFAULT = 2 * SKEIN_BLOCK_STAGES + 3 * KECCAK_STAGES + 2;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        stateIdle  = 2'd0,
        stateRun   = 2'd1,
        stateDrain = 2'd2
    } dispatchState_t;

endpackage

// File: rtl/nexus_result_fifo.sv
// Winning-nonce FIFO: registered storage, first-word-fall-through head, and
// push/pop in the same cycle at any occupancy (a push into a full FIFO lands when a pop frees the slot).
module nexus_result_fifo
    import nexus_nonce_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  nonce_t pushData,
    input  logic   pop,
    output nonce_t headData,
    output logic   notEmpty,
    output logic   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    nonce_t           mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    nonce_t           lastHead;
    logic             doPush;
    logic             doPop;

    assign notEmpty = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign doPop    = pop & notEmpty;
    assign doPush   = push & (~full | doPop);

    // When empty the host keeps seeing the most recently popped nonce.
    assign headData = notEmpty ? mem[rdPtr] : lastHead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            lastHead <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                lastHead <= mem[rdPtr];
                rdPtr    <= rdPtr + 1'b1;
            end
            if (doPush != doPop) begin
                count <= doPush ? count + 1'b1 : count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nexus_nonce_dispatch.sv
// Issues sequential nonces into the SK1024 core, matches returning qwords to their
// nonces and queues hits for the host. Define NXS_HASH_COUNTER_EN to add the HashCount output.
module nexus_nonce_dispatch
    import nexus_nonce_dispatch_pkg::*;
#(
    parameter int PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               HashRst,
    input  logic               Start,
    input  logic               Stop,
    input  logic [NONCE_W-1:0] StartNonce,
    input  logic [QWORD_W-1:0] Target,
    output logic [NONCE_W-1:0] NonceOut,
    output logic               IssueValid,
    input  logic [QWORD_W-1:0] HashQword,
    output logic               Busy,
    output logic [NONCE_W-1:0] ResultNonce,
    output logic               ResultValid,
    input  logic               ResultReady,
    output logic               Overflow
`ifdef NXS_HASH_COUNTER_EN
    ,
    output logic [HASH_COUNT_W-1:0] HashCount
`endif
);

    dispatchState_t          state;
    dispatchState_t          stateNext;
    logic [PIPE_LATENCY-1:0] validSr;
    logic                    slotTail;
    logic                    hit;
    logic                    startAccept;
    logic                    runAdvance;
    logic                    fifoFull;
    nonce_t                  outNonce;
    logic [QWORD_W-1:0]      targetReg;

    assign slotTail    = validSr[PIPE_LATENCY-1];
    assign hit         = slotTail & (HashQword <= targetReg);
    assign startAccept = (state == stateIdle) & Start;
    assign runAdvance  = (state == stateRun) & ~Stop;

    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) begin
            state <= stateIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Drain ends on the edge that consumes the last valid slot, so Busy drops right after it.
    always_comb begin
        stateNext = state;
        unique case (state)
            stateIdle:  if (Start) stateNext = stateRun;
            stateRun:   if (Stop) stateNext = stateDrain;
            stateDrain: if (validSr[PIPE_LATENCY-2:0] == '0) stateNext = stateIdle;
            default:    stateNext = stateIdle;
        endcase
    end

    always_comb begin
        IssueValid = (state == stateRun);
        Busy       = (state != stateIdle);
    end

    // outNonce counts consumed slots rather than subtracting the latency from NonceOut,
    // so it stays correct once issuing stops and NonceOut freezes.
    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) begin
            NonceOut  <= '0;
            validSr   <= '0;
            outNonce  <= '0;
            targetReg <= '0;
            Overflow  <= 1'b0;
        end else begin
            validSr <= {validSr[PIPE_LATENCY-2:0], IssueValid};
            if (startAccept) begin
                NonceOut  <= StartNonce;
                outNonce  <= StartNonce;
                targetReg <= Target;
            end else begin
                if (runAdvance) NonceOut <= NonceOut + 1'b1;
                if (slotTail)   outNonce <= outNonce + 1'b1;
            end
            if (hit & fifoFull & ~ResultReady) begin
                Overflow <= 1'b1;
            end else if (startAccept) begin
                Overflow <= 1'b0;
            end
        end
    end

`ifdef NXS_HASH_COUNTER_EN
    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) begin
            HashCount <= '0;
        end else if (startAccept) begin
            HashCount <= '0;
        end else if (slotTail) begin
            HashCount <= HashCount + 1'b1;
        end
    end
`endif

    nexus_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) resultFifo (
        .clk      (clk),
        .rst      (HashRst),
        .push     (hit),
        .pushData (outNonce),
        .pop      (ResultReady),
        .headData (ResultNonce),
        .notEmpty (ResultValid),
        .full     (fifoFull)
    );

endmodule

// File: tb/tb_nexus_nonce_dispatch.sv
// Bench for nexus_nonce_dispatch: a delay-line hash core, a queue-based model of
// issue/result/FIFO behaviour checked every cycle, and directed scenarios with literal expectations.
module tb_nexus_nonce_dispatch;

    localparam int L     = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        HashRst;
    logic        Start;
    logic        Stop;
    logic        ResultReady;
    logic [63:0] StartNonce;
    logic [63:0] Target;
    logic [63:0] NonceOut;
    logic [63:0] HashQword;
    logic [63:0] ResultNonce;
    logic        IssueValid;
    logic        Busy;
    logic        ResultValid;
    logic        Overflow;

    int assertCount = 0;
    int failCount   = 0;
    int edgeCnt     = 0;
    int qMode       = 0;

    logic [63:0] pipe [L];
    logic [63:0] popLog [$];
    logic [63:0] expQ [$];

    logic        sStart, sStop, sReady, sRst;
    logic [63:0] sStartNonce, sTarget;

    typedef struct {
        int          due;
        logic [63:0] nonce;
    } slot_t;

    always #5 clk = ~clk;

    nexus_nonce_dispatch #(
        .PIPE_LATENCY(L),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .HashRst     (HashRst),
        .Start       (Start),
        .Stop        (Stop),
        .StartNonce  (StartNonce),
        .Target      (Target),
        .NonceOut    (NonceOut),
        .IssueValid  (IssueValid),
        .HashQword   (HashQword),
        .Busy        (Busy),
        .ResultNonce (ResultNonce),
        .ResultValid (ResultValid),
        .ResultReady (ResultReady),
        .Overflow    (Overflow)
    );

    // Hash function stand-ins: all-hit, one golden nonce, and qword = 5 + nonce[1:0].
    function automatic logic [63:0] coreQword(input logic [63:0] n, input int mode);
        case (mode)
            0:       return 64'd0;
            1:       return (n == 64'h0000_0001_FCAF_C044) ? 64'h0000_0000_0123_4567
                                                           : 64'h0000_0001_0000_0000;
            default: return 64'd5 + {62'd0, n[1:0]};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < L; i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
        pipe[0] <= NonceOut;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    assign HashQword = coreQword(pipe[L-1], qMode);

    always @(posedge clk) begin
        edgeCnt     <= edgeCnt + 1;
        sStart      <= Start;
        sStop       <= Stop;
        sReady      <= ResultReady;
        sRst        <= HashRst;
        sStartNonce <= StartNonce;
        sTarget     <= Target;
    end

    always @(posedge clk) begin
        if (!HashRst && ResultValid && ResultReady) popLog.push_back(ResultNonce);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Model: every issued nonce is remembered with the edge at which its qword is due.
    initial begin : modelCompare
        int          mState;
        logic [63:0] mNonce;
        logic [63:0] mTarget;
        logic [63:0] mLast;
        logic        mOverflow;
        logic [63:0] mQ [$];
        slot_t       pend [$];
        slot_t       s;
        logic        hitNow;
        logic [63:0] hitNonce;
        logic [63:0] expHead;
        int          e;
        mState = 0; mNonce = '0; mTarget = '0; mLast = '0; mOverflow = 1'b0;
        forever begin
            @(negedge clk);
            e = edgeCnt;
            if (HashRst || sRst) begin
                mState = 0; mNonce = '0; mTarget = '0; mLast = '0; mOverflow = 1'b0;
                mQ.delete();
                pend.delete();
            end else begin
                if (mState == 1) begin
                    s.due   = e + L;
                    s.nonce = mNonce;
                    pend.push_back(s);
                end
                hitNow   = 1'b0;
                hitNonce = '0;
                if (pend.size() > 0 && pend[0].due == e) begin
                    s        = pend.pop_front();
                    hitNow   = (coreQword(s.nonce, qMode) <= mTarget);
                    hitNonce = s.nonce;
                end
                if (sReady && mQ.size() > 0) mLast = mQ.pop_front();
                if (hitNow) begin
                    if (mQ.size() < DEPTH) mQ.push_back(hitNonce);
                    else mOverflow = 1'b1;
                end
                case (mState)
                    0: if (sStart) begin
                           mState = 1; mNonce = sStartNonce; mTarget = sTarget; mOverflow = 1'b0;
                       end
                    1: if (sStop) mState = 2; else mNonce = mNonce + 64'd1;
                    default: if (pend.size() == 0) mState = 0;
                endcase
            end
            expHead = (mQ.size() > 0) ? mQ[0] : mLast;
            checkOutput("IssueValid", IssueValid, mState == 1);
            checkOutput("NonceOut", NonceOut, mNonce);
            checkOutput("Busy", Busy, mState != 0);
            checkOutput("ResultValid", ResultValid, mQ.size() > 0);
            checkOutput("ResultNonce", ResultNonce, expHead);
            checkOutput("Overflow", Overflow, mOverflow);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic [63:0] sn, input logic [63:0] tg);
        Start      = st;
        Stop       = sp;
        StartNonce = sn;
        Target     = tg;
        tick();
        Start = 1'b0;
        Stop  = 1'b0;
    endtask

    task automatic runBurst(input logic [63:0] sn, input logic [63:0] tg, input int issues);
        applyStimulus(1'b1, 1'b0, sn, tg);
        repeat (issues - 1) tick();
        applyStimulus(1'b0, 1'b1, sn, tg);
    endtask

    task automatic waitIdle(input int budget);
        int i;
        i = 0;
        while (Busy && i < budget) begin
            tick();
            i++;
        end
        if (Busy) checkOutput("idleTimeoutBusy", Busy, 0);
    endtask

    task automatic drainFifo();
        int i;
        ResultReady = 1'b1;
        i = 0;
        while (ResultValid && i < 2 * DEPTH + 2) begin
            tick();
            i++;
        end
        tick();
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "Count"}, popLog.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < popLog.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), popLog[i], expQ[i]);
        end
        popLog.delete();
        expQ.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        int m0;
        int firstRv;
        int busyLow;
        HashRst = 1'b1; Start = 1'b0; Stop = 1'b0; ResultReady = 1'b0;
        StartNonce = '0; Target = '0;
        repeat (2) tick();
        checkOutput("rstNonceOut", NonceOut, 64'd0);
        checkOutput("rstIssueValid", IssueValid, 0);
        checkOutput("rstBusy", Busy, 0);
        checkOutput("rstResultNonce", ResultNonce, 64'd0);
        checkOutput("rstResultValid", ResultValid, 0);
        checkOutput("rstOverflow", Overflow, 0);
        HashRst = 1'b0;
        tick();

        $display("[TB] basic latency and ordering");
        qMode = 0; ResultReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        n0 = edgeCnt;
        repeat (4) tick();
        applyStimulus(1'b0, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        m0 = edgeCnt;
        firstRv = -1; busyLow = -1;
        for (int i = 0; i < 40 && busyLow < 0; i++) begin
            @(negedge clk);
            if (ResultValid && firstRv < 0) firstRv = edgeCnt + 1;
            if (!Busy) busyLow = edgeCnt + 1;
        end
        checkOutput("firstResultCycle", firstRv - n0, 10);
        checkOutput("busyFallCycle", busyLow - m0, L + 1);
        repeat (3) tick();
        for (int i = 0; i < 5; i++) expQ.push_back(64'h10 + 64'(i));
        checkLog("basicResults");

        $display("[TB] golden nonce");
        qMode = 1;
        runBurst(64'h0000_0001_FCAF_C044, 64'h0000_0000_FFFF_FFFF, 3);
        waitIdle(40);
        drainFifo();
        expQ.push_back(64'h0000_0001_FCAF_C044);
        checkLog("goldenResult");

        $display("[TB] nonce wrap");
        qMode = 0;
        runBurst(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        waitIdle(40);
        drainFifo();
        expQ.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        expQ.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        expQ.push_back(64'h0);
        expQ.push_back(64'h1);
        checkLog("wrapResults");

        $display("[TB] overflow with host stalled");
        ResultReady = 1'b0;
        runBurst(64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 6);
        waitIdle(40);
        checkOutput("ovfResultValid", ResultValid, 1);
        checkOutput("ovfFlag", Overflow, 1);
        drainFifo();
        checkOutput("ovfSticky", Overflow, 1);
        for (int i = 0; i < 4; i++) expQ.push_back(64'h100 + 64'(i));
        checkLog("ovfResults");

        $display("[TB] pop coincident with push at full");
        ResultReady = 1'b0;
        applyStimulus(1'b1, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
        n0 = edgeCnt;
        checkOutput("ovfClearedByStart", Overflow, 0);
        repeat (4) tick();
        applyStimulus(1'b0, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
        while (edgeCnt < n0 + 12) tick();
        checkOutput("fullBeforePop", ResultValid, 1);
        ResultReady = 1'b1;
        tick();
        ResultReady = 1'b0;
        waitIdle(40);
        checkOutput("noDropOverflow", Overflow, 0);
        drainFifo();
        for (int i = 0; i < 5; i++) expQ.push_back(64'h200 + 64'(i));
        checkLog("noDropResults");

        $display("[TB] reset mid-run");
        qMode = 0; ResultReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) tick();
        HashRst = 1'b1;
        #1;
        checkOutput("midRstNonceOut", NonceOut, 64'd0);
        checkOutput("midRstIssueValid", IssueValid, 0);
        checkOutput("midRstBusy", Busy, 0);
        tick();
        HashRst = 1'b0;
        repeat (20) tick();
        checkOutput("midRstResultValid", ResultValid, 0);
        checkLog("midRstResults");

        $display("[TB] ignored controls and exact target");
        qMode = 2; ResultReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 64'h20, 64'h5);
        checkOutput("startWinsIssue", IssueValid, 1);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("drainIgnoresStart", IssueValid, 0);
        applyStimulus(1'b0, 1'b1, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF);
        waitIdle(40);
        drainFifo();
        applyStimulus(1'b0, 1'b1, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("idleIgnoresStop", Busy, 0);
        checkOutput("nonceHeldAfterRun", NonceOut, 64'h27);
        expQ.push_back(64'h20);
        expQ.push_back(64'h24);
        checkLog("targetResults");

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
